// File: rtl/maxnet_engine_if.sv
// Handshake and result bundle between a Maxnet requester and the engine.
// The requester drives start/x_in; the engine returns status and the published result.
interface maxnet_engine_if #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 16
);
  localparam int IDX_W  = (N > 2) ? $clog2(N) : 1;
  localparam int ITER_W = $clog2(MAX_ITER + 1);

  logic                 start;
  logic [N*WIDTH-1:0]   x_in;
  logic                 busy;
  logic                 done;
  logic [IDX_W-1:0]     winner_idx;
  logic [WIDTH-1:0]     winner_value;
  logic                 winner_valid;
  logic                 timeout;
  logic [ITER_W-1:0]    iter_count;

  modport master (
    output start, x_in,
    input  busy, done, winner_idx, winner_value, winner_valid, timeout, iter_count
  );

  modport slave (
    input  start, x_in,
    output busy, done, winner_idx, winner_value, winner_valid, timeout, iter_count
  );
endinterface

// File: rtl/maxnet_engine.sv
// Winner-take-all engine: iterates lateral inhibition with a ReLU clamp until at
// most one activation survives (or MAX_ITER updates elapse), then publishes it.
module maxnet_engine #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 16
) (
  input  logic            clk,
  input  logic            rst,
  maxnet_engine_if.slave  bus
);
  localparam int IDX_W  = (N > 2) ? $clog2(N) : 1;
  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam int SUM_W  = WIDTH + $clog2(N);
  localparam int CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    a_q [N];
  logic [WIDTH-1:0]    c_q [N];
  logic [ITER_W-1:0]   iter_q;
  logic                busy_q;
  logic                done_q;
  logic [IDX_W-1:0]    idx_q;
  logic [WIDTH-1:0]    value_q;
  logic                valid_q;
  logic                timeout_q;
  logic [ITER_W-1:0]   count_q;

  logic [WIDTH-1:0]    a_d [N];
  logic [SUM_W-1:0]    inh_s [N];
  logic [SUM_W-1:0]    sum_s;
  logic [CNT_W-1:0]    nz_cnt_s;
  logic                multi_s;
  logic                win_any_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic [WIDTH-1:0]    win_val_s;

  // Next activations, survivor count and lowest-index survivor from the current a[]
  always_comb begin
    sum_s     = '0;
    nz_cnt_s  = '0;
    win_any_s = 1'b0;
    win_idx_s = '0;
    win_val_s = '0;
    for (int i = 0; i < N; i++) begin
      sum_s    = sum_s + SUM_W'(a_q[i]);
      nz_cnt_s = nz_cnt_s + CNT_W'(a_q[i] != '0);
    end
    for (int i = 0; i < N; i++) begin
      inh_s[i] = (sum_s - SUM_W'(a_q[i])) >> EPS_SHIFT;
      a_d[i]   = (SUM_W'(a_q[i]) > inh_s[i]) ? WIDTH'(SUM_W'(a_q[i]) - inh_s[i]) : '0;
    end
    // Walk downward so the lowest nonzero index is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      win_idx_s = (a_q[i] != '0) ? IDX_W'(i) : win_idx_s;
      win_val_s = (a_q[i] != '0) ? c_q[i]    : win_val_s;
      win_any_s = (a_q[i] != '0) ? 1'b1      : win_any_s;
    end
    multi_s = (nz_cnt_s > CNT_W'(1));
  end

  // Control FSM, activation/capture registers and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            for (int i = 0; i < N; i++) begin
              a_q[i] <= bus.x_in[i*WIDTH +: WIDTH];
              c_q[i] <= bus.x_in[i*WIDTH +: WIDTH];
            end
            iter_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_ITER;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ITER: begin
          if (!multi_s || (iter_q == ITER_W'(MAX_ITER))) begin
            idx_q     <= win_idx_s;
            value_q   <= win_val_s;
            valid_q   <= win_any_s;
            timeout_q <= multi_s;
            count_q   <= iter_q;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            for (int i = 0; i < N; i++) begin
              a_q[i] <= a_d[i];
            end
            iter_q  <= iter_q + ITER_W'(1);
            state_q <= S_ITER;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.winner_idx   = idx_q;
  assign bus.winner_value = value_q;
  assign bus.winner_valid = valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.iter_count   = count_q;
endmodule

// File: tb/tb_maxnet_engine.sv
// Self-checking bench for maxnet_engine (N=4, WIDTH=8, EPS_SHIFT=2, MAX_ITER=16).
// Result tuple = {idx[1:0], value[7:0], valid, timeout, iter_count[4:0]}.
module tb_maxnet_engine;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  logic [16:0] obs_t;
  int          obs_lat;
  logic        obs_busy;

  maxnet_engine_if #(.N(4), .WIDTH(8), .MAX_ITER(16)) bus ();

  maxnet_engine #(.N(4), .WIDTH(8), .EPS_SHIFT(2), .MAX_ITER(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] cur_tuple();
    return {bus.winner_idx, bus.winner_value, bus.winner_valid, bus.timeout, bus.iter_count};
  endfunction

  // Behavioural model: iterate the inhibition rule on plain integers.
  task automatic model(input logic [31:0] xv, output logic [16:0] exp_t);
    int a[4];
    int s, nz, it, inh, idx;
    bit to;
    logic [31:0] xc;
    logic [7:0] val;
    xc = xv;
    for (int i = 0; i < 4; i++) a[i] = int'(xc[i*8 +: 8]);
    it = 0;
    to = 1'b0;
    while (1) begin
      nz = 0;
      s  = 0;
      for (int i = 0; i < 4; i++) begin
        if (a[i] != 0) nz++;
        s += a[i];
      end
      if (nz <= 1) break;
      if (it == 16) begin
        to = 1'b1;
        break;
      end
      for (int i = 0; i < 4; i++) begin
        inh  = (s - a[i]) / 4;
        a[i] = (a[i] > inh) ? a[i] - inh : 0;
      end
      it++;
    end
    idx = -1;
    for (int i = 3; i >= 0; i--) if (a[i] != 0) idx = i;
    if (idx < 0) exp_t = {2'd0, 8'd0, 1'b0, to, 5'(it)};
    else begin
      val   = xc[idx*8 +: 8];
      exp_t = {2'(idx), val, 1'b1, to, 5'(it)};
    end
  endtask

  // Start one run, then wait (bounded) for done; obs_lat = publish edge index, -1 on expiry.
  task automatic run(input logic [31:0] xv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = xv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_in  = $urandom;
    obs_busy  = bus.busy;
    obs_lat   = -1;
    obs_t     = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        obs_lat = cyc;
        obs_t   = cur_tuple();
        break;
      end
    end
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_status busy/done=%b want 00", {bus.busy, bus.done});
    else pass_cnt++;
    total_cnt++;
    if (cur_tuple() !== 17'd0) $display("FAIL reset_result got %h want 0", cur_tuple());
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [31:0] xs [4];
    logic [16:0] want [4];
    xs[0] = {8'd40, 8'd30, 8'd20, 8'd10}; want[0] = {2'd3, 8'd40, 1'b1, 1'b0, 5'd4};
    xs[1] = {8'd0,  8'd7,  8'd0,  8'd0};  want[1] = {2'd2, 8'd7,  1'b1, 1'b0, 5'd0};
    xs[2] = 32'd0;                        want[2] = {2'd0, 8'd0,  1'b0, 1'b0, 5'd0};
    xs[3] = {8'd0,  8'd0,  8'd50, 8'd50}; want[3] = {2'd0, 8'd50, 1'b1, 1'b1, 5'd16};
    for (int k = 0; k < 4; k++) begin
      run(xs[k]);
      total_cnt++;
      if (obs_t !== want[k]) $display("FAIL directed%0d_result got %h want %h", k, obs_t, want[k]);
      else pass_cnt++;
      total_cnt++;
      if (obs_lat !== int'(want[k][4:0]) + 1) $display("FAIL directed%0d_latency got %0d want %0d", k, obs_lat, int'(want[k][4:0]) + 1);
      else pass_cnt++;
      total_cnt++;
      if (obs_busy !== 1'b1) $display("FAIL directed%0d_busy got %b want 1", k, obs_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] xv;
    logic [16:0] exp_t;
    for (int k = 0; k < 25; k++) begin
      for (int c = 0; c < 4; c++) xv[c*8 +: 8] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) xv[15:8] = xv[7:0];
      model(xv, exp_t);
      run(xv);
      total_cnt++;
      if (obs_t !== exp_t) $display("FAIL random%0d_result x=%h got %h want %h", k, xv, obs_t, exp_t);
      else pass_cnt++;
      total_cnt++;
      if (obs_lat !== int'(exp_t[4:0]) + 1) $display("FAIL random%0d_latency got %0d want %0d", k, obs_lat, int'(exp_t[4:0]) + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    logic [16:0] want_a;
    logic [16:0] want_b;
    int          seen;
    want_a = {2'd3, 8'd40, 1'b1, 1'b0, 5'd4};
    want_b = {2'd2, 8'd200, 1'b1, 1'b0, 5'd0};
    @(negedge clk);
    bus.start = 1'b1; bus.x_in = {8'd40, 8'd30, 8'd20, 8'd10};
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.x_in = {8'd0, 8'd200, 8'd0, 8'd0};
    @(negedge clk);
    bus.start = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (seen !== 1) $display("FAIL ignore_done got no done want done");
    else pass_cnt++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL ignore_idle busy/done=%b want 00", {bus.busy, bus.done});
    else pass_cnt++;
    total_cnt++;
    if (cur_tuple() !== want_a) $display("FAIL ignore_result got %h want %h", cur_tuple(), want_a);
    else pass_cnt++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    total_cnt++;
    if (cur_tuple() !== want_a) $display("FAIL ignore_hold got %h want %h", cur_tuple(), want_a);
    else pass_cnt++;
    seen = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    total_cnt++;
    if ((seen !== 1) || (cur_tuple() !== want_b)) $display("FAIL ignore_newrun got %h want %h", cur_tuple(), want_b);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.x_in = {8'd40, 8'd30, 8'd20, 8'd10};
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if ((bus.busy !== 1'b1) || (cur_tuple() === 17'd0)) $display("FAIL areset_pre busy=%b result=%h want busy 1 and nonzero result", bus.busy, cur_tuple());
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL areset_status busy/done=%b want 00", {bus.busy, bus.done});
    else pass_cnt++;
    total_cnt++;
    if (cur_tuple() !== 17'd0) $display("FAIL areset_result got %h want 0", cur_tuple());
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    run({8'd40, 8'd30, 8'd20, 8'd10});
    total_cnt++;
    if (obs_t !== {2'd3, 8'd40, 1'b1, 1'b0, 5'd4}) $display("FAIL areset_rerun got %h want %h", obs_t, {2'd3, 8'd40, 1'b1, 1'b0, 5'd4});
    else pass_cnt++;
    total_cnt++;
    if (obs_lat !== 5) $display("FAIL areset_latency got %0d want 5", obs_lat);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.x_in  = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_directed();
    test_random();
    test_ignore_start();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/maxnet_engine.md
Name: maxnet_engine

Overview:
- Parametrised winner-take-all (Maxnet) engine: captures N unsigned WIDTH-bit candidates and iterates mutual lateral inhibition with a ReLU activation until at most one activation is nonzero.
- Reports the index and the original value of the surviving candidate.
- Generalises the fixed 4-input, 5-bit max-finder datapath: any channel count, data width, shift-based inhibition weight, iteration timeout, and a start/done handshake with its own FSM.

Parameters:
- N, 4, number of candidate channels (>=2)
- WIDTH, 8, bits per candidate (unsigned)
- EPS_SHIFT, 2, inhibition weight epsilon = 2^-EPS_SHIFT, applied as a right shift
- MAX_ITER, 16, maximum inhibition iterations before forced termination (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- start  in  1  request; sampled only in IDLE
- x_in  in  N*WIDTH  candidates; channel i = x_in[i*WIDTH +: WIDTH]
- busy  out  1  high in ITER and DONE states
- done  out  1  one-cycle pulse when a result is published
- winner_idx  out  IDX_W=max(1,$clog2(N))  winning channel
- winner_value  out  WIDTH  original captured value of the winner
- winner_valid  out  1  0 if every activation reached zero
- timeout  out  1  1 if the run ended by reaching MAX_ITER
- iter_count  out  ITER_W=$clog2(MAX_ITER+1)  number of updates performed

Behaviour:
- rst=0, asynchronous, at any time including mid-run: state=IDLE, all activation and capture registers=0, done=0, busy=0, winner_idx=0, winner_value=0, winner_valid=0, timeout=0, iter_count=0.
- FSM states: IDLE, ITER, DONE.
- IDLE, start=1 at a clock edge:
  - copy x_in into the activation registers a[i] and the capture registers c[i]
  - iter=0, clear timeout
  - next state ITER
- start while busy=1 is ignored. x_in is don't-care outside the sampling edge.
- ITER, each edge, evaluated on the current a[] (priority order):
  1. If the count of nonzero a[i] is <=1: publish the result, go to DONE; a[] is not updated.
  2. Else if iter==MAX_ITER: publish with timeout=1, go to DONE.
  3. Else update every a[i] simultaneously and increment iter.
- Update rule:
  - S = sum of all a[j], width WIDTH+$clog2(N), no overflow.
  - inh_i = (S - a[i]) >> EPS_SHIFT (logical shift).
  - a[i]' = (a[i] > inh_i) ? a[i] - inh_i : 0. This is a ReLU clamp, so the result always fits in WIDTH bits.
- Publish:
  - winner_idx = lowest index with a[i]!=0
  - winner_value = c[winner_idx]
  - winner_valid=1
  - if every a[i]==0: winner_idx=0, winner_value=0, winner_valid=0
  - iter_count=iter
- DONE: done=1 for exactly this one cycle; next state IDLE unconditionally. A start during DONE is ignored.
- Result outputs hold their values until the next publish or reset.
- Latency: k updates gives done high in cycle k+2 after the start-sampling edge (edge 0). The publish is registered at edge k+1.
- Ties: equal survivors may never separate. The run terminates via timeout, and the lowest index wins.

Test Plan:
- N=4, WIDTH=8, EPS_SHIFT=2, x={10,20,30,40}, start 1 cycle.
  - Trajectory: {0,0,13,25}, {0,0,7,22}, {0,0,2,21}, {0,0,0,21}.
  - Required: done pulses after edge 5; winner_idx=3, winner_value=40, winner_valid=1, timeout=0, iter_count=4.
- x={0,0,7,0} -> done after edge 1; winner_idx=2, winner_value=7, valid=1, iter_count=0.
- x={0,0,0,0} -> done after edge 1; winner_valid=0, winner_idx=0, winner_value=0, iter_count=0.
- Tie x={50,50,0,0}, MAX_ITER=16 -> activations settle at 3,3; run ends by timeout.
  - Required: timeout=1, iter_count=16, winner_idx=0, winner_value=50, valid=1.
- Re-assert start mid-run (with different x), then assert start during the DONE cycle -> both ignored; the result matches the first run.
  - Next start in IDLE -> a new run starts; outputs hold until its publish.
- Drive rst=0 asynchronously at mid-edge during ITER of the first scenario.
  - Required: busy, done and all outputs go to 0 immediately, without waiting for a clock edge.
  - Then release reset and start a new run -> correct result, iter_count counted from 0.
